// File: rtl/dmem_responder_if.sv
// Core data-memory bus: held request (req/we/addr/wdata), one-cycle ready/rdata response.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input  ready, rdata);
    modport slave  (input  req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/dmem_responder.sv
// Data-side bus target: word RAM below 0x8000_0000, I/O window (TX FIFO + status) above.
// Stores to TXDATA stall in TXWAIT while the byte FIFO feeding the UART is full.
module dmem_responder #(
    parameter int unsigned RAM_AW   = 12,
    parameter int unsigned TX_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);
    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;
    localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        TXWAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_ram [RAM_WORDS];
    logic [7:0]         r_fifo [TX_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_tx_valid;
    logic               r_ready;
    logic [31:0]        r_rdata;

    logic               w_is_io;
    logic [1:0]         w_io_off;
    logic [RAM_AW-1:0]  w_ram_idx;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_is_txdata_st;
    logic               w_push;
    logic               w_pop;
    logic               w_ram_we;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [31:0]        w_status;
    logic [31:0]        w_load_data;
    logic [31:0]        w_rdata_nxt;
    logic               w_unused;

    // Address decode; RAM aliases on the ignored upper bits
    assign w_is_io        = bus.addr[31];
    assign w_io_off       = bus.addr[3:2];
    assign w_ram_idx      = bus.addr[RAM_AW+1:2];
    assign w_unused       = ^{bus.addr[30:RAM_AW+2], bus.addr[1:0]};

    assign w_tx_full      = (r_count == CNT_W'(TX_DEPTH));
    assign w_tx_empty     = (r_count == '0);
    assign w_is_txdata_st = bus.we && w_is_io && (w_io_off == 2'd0);
    assign w_pop          = r_tx_valid && tx_ready;
    assign w_status       = {16'b0, 8'(r_count), 6'b0, w_tx_empty, w_tx_full};

    assign bus.ready      = r_ready;
    assign bus.rdata      = r_rdata;
    assign tx_valid       = r_tx_valid;
    assign tx_data        = r_fifo[r_rd_ptr];

    // Load data mux, using occupancy as it stands before this cycle's pop
    always_comb begin
        w_load_data = '0;
        if (!w_is_io) begin
            w_load_data = r_ram[w_ram_idx];
        end else if (w_io_off == 2'd1) begin
            w_load_data = w_status;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ram_we    = 1'b0;
        w_rdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (w_is_txdata_st && w_tx_full) begin
                        w_state_nxt = TXWAIT;
                    end else begin
                        w_state_nxt = RESP;
                        w_push      = w_is_txdata_st;
                        w_ram_we    = bus.we && !w_is_io;
                        if (!bus.we) begin
                            w_rdata_nxt = w_load_data;
                        end
                    end
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            TXWAIT: begin
                // A same-cycle pop is not seen until the next check
                if (!w_tx_full) begin
                    w_state_nxt = RESP;
                    w_push      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= (w_state_nxt == RESP);
            r_rdata    <= w_rdata_nxt;
            r_count    <= w_count_nxt;
            r_tx_valid <= (w_count_nxt != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= bus.wdata;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.wdata[7:0];
        end
    end
endmodule
